pipe_skid_reg: RTL and testbench
================================

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 Parameter DATA_W, default 32, payload width in bits.
REQ-002 Parameter ADDR_W, default 5, destination register address width.
REQ-003 Parameter ZERO_KILL, default 1; when 1, out_we SHALL be forced to 0 whenever out_addr is all-zero.
REQ-004 clk  in  1  clock; all state SHALL update on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 in_valid  in  1  upstream entry present.
REQ-007 in_ready  out  1  stage can accept an entry this cycle; registered.
REQ-008 in_we  in  1  entry writes the register file.
REQ-009 in_addr  in  ADDR_W  destination register address.
REQ-010 in_data  in  DATA_W  payload.
REQ-011 flush  in  1  discard all held entries.
REQ-012 out_valid  out  1  held entry presented downstream.
REQ-013 out_ready  in  1  downstream consumes the presented entry.
REQ-014 out_we, out_addr, out_data  out  1/ADDR_W/DATA_W  presented entry fields.
REQ-015 occ  out  2  entries held (0, 1 or 2).

Function
REQ-016 Storage SHALL be one main register (presented downstream) and one skid register; states EMPTY (occ=0), FULL (occ=1), SKID (occ=2).
REQ-017 Accept SHALL occur when in_valid && in_ready; consume SHALL occur when out_valid && out_ready.
REQ-018 EMPTY: accept -> FULL, main<=input; no accept -> stay EMPTY.
REQ-019 FULL: accept && consume -> FULL, main<=input; accept && !consume -> SKID, skid<=input; consume && !accept -> EMPTY; neither -> hold.
REQ-020 SKID: consume -> FULL, main<=skid; no consume -> hold; in_ready=0, so no accept.
REQ-021 in_ready SHALL be 1 in EMPTY and FULL and 0 in SKID, as a registered value taking effect the cycle after the state change.
REQ-022 Latency SHALL be exactly one cycle from accept to out_valid when the stage is EMPTY.
REQ-023 Ordering SHALL be strict FIFO; no entry is dropped or duplicated absent flush.
REQ-024 out_valid SHALL be 1 in FULL and SKID and 0 in EMPTY.
REQ-025 out_we SHALL be 0 whenever out_valid=0 (bubble never writes).
REQ-026 With ZERO_KILL=1, out_we SHALL also be 0 when out_addr==0; out_data and out_addr are still presented.
REQ-027 out_addr/out_data SHALL hold their values while out_valid && !out_ready.
REQ-028 flush SHALL override all other events: next state EMPTY, main and skid fields cleared to 0, in_ready=1 next cycle.
REQ-029 An input offered in the flush cycle SHALL be dropped.
REQ-030 A consume in the flush cycle SHALL count as completed; downstream sees out_valid=0 the next cycle.
REQ-031 occ SHALL equal the number of valid entries, updated in the same cycle as the state.

Reset
REQ-032 During rst, next-cycle values SHALL be: state EMPTY; out_valid=0, out_we=0, out_addr=0, out_data=0, occ=0; in_ready=1.
REQ-033 rst SHALL take priority over flush and all handshakes; entries in flight at reset SHALL be lost.

Verification
REQ-034 Stream: out_ready=1; push addr 3/data 0xA, addr 4/data 0xB on consecutive cycles -> outputs one cycle later in order, we=1, occ stays 1, in_ready stays 1.
REQ-035 Backpressure: FULL with 0xA, out_ready=0, push 0xB -> occ=2, in_ready=0 next cycle, 0xA held. Raise out_ready -> 0xA then 0xB, in_ready=1 after SKID exits.
REQ-036 Flush in SKID with in_valid=1, data 0xC -> next cycle occ=0, out_valid=0, out_data=0, in_ready=1; 0xC never appears.
REQ-037 ZERO_KILL: push we=1, addr=0, data 0xFF -> out_valid=1, out_data=0xFF, out_we=0. Repeat with ZERO_KILL=0 -> out_we=1.
REQ-038 Reset mid-operation: assert rst in SKID -> next cycle all outputs 0, occ=0, in_ready=1. Push after release -> normal one-cycle latency.

Source files
------------

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg -- single pipeline stage with a one-entry skid buffer.
//
// Holds up to two register-file write entries {we, addr, data}. The main
// register is always the one presented downstream; the skid register catches
// an entry accepted in the same cycle the downstream stalls, so in_ready can
// be a registered signal without losing data. Entries leave in strict FIFO
// order.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   in_valid/in_ready upstream handshake (in_ready registered)
//   in_we/addr/data   incoming entry fields
//   flush             discard all held entries (and any offered input)
//   out_valid/ready   downstream handshake
//   out_we/addr/data  presented entry (out_we gated by valid and ZERO_KILL)
//   occ               number of held entries (0..2)
module pipe_skid_reg #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter bit ZERO_KILL = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_addr,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occ
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              main_we_q, main_we_d;
  logic [ADDR_W-1:0] main_addr_q, main_addr_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic              skid_we_q, skid_we_d;
  logic [ADDR_W-1:0] skid_addr_q, skid_addr_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_we_q, out_we_d;
  logic [1:0]        occ_q, occ_d;

  logic              accept_s;
  logic              consume_s;

  // A write to register 0 is architecturally a no-op; suppress it when enabled.
  function automatic logic we_killed(input logic [ADDR_W-1:0] addr);
    return ZERO_KILL && (addr == {ADDR_W{1'b0}});
  endfunction

  assign accept_s  = in_valid && in_ready_q;
  assign consume_s = out_valid_q && out_ready;

  // Next-state logic for storage and the state machine.
  always_comb begin
    state_d     = state_q;
    main_we_d   = main_we_q;
    main_addr_d = main_addr_q;
    main_data_d = main_data_q;
    skid_we_d   = skid_we_q;
    skid_addr_d = skid_addr_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      // Flush wins over every handshake; an offered input is dropped.
      state_d     = ST_EMPTY;
      main_we_d   = 1'b0;
      main_addr_d = {ADDR_W{1'b0}};
      main_data_d = {DATA_W{1'b0}};
      skid_we_d   = 1'b0;
      skid_addr_d = {ADDR_W{1'b0}};
      skid_data_d = {DATA_W{1'b0}};
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_s) begin
            state_d     = ST_FULL;
            main_we_d   = in_we;
            main_addr_d = in_addr;
            main_data_d = in_data;
          end else begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (accept_s && consume_s) begin
            state_d     = ST_FULL;
            main_we_d   = in_we;
            main_addr_d = in_addr;
            main_data_d = in_data;
          end else if (accept_s) begin
            // Downstream stalled: park the new entry behind the main one.
            state_d     = ST_SKID;
            skid_we_d   = in_we;
            skid_addr_d = in_addr;
            skid_data_d = in_data;
          end else if (consume_s) begin
            state_d = ST_EMPTY;
          end else begin
            state_d = ST_FULL;
          end
        end
        ST_SKID: begin
          // in_ready is low here, so no accept can occur.
          if (consume_s) begin
            state_d     = ST_FULL;
            main_we_d   = skid_we_q;
            main_addr_d = skid_addr_q;
            main_data_d = skid_data_q;
          end else begin
            state_d = ST_SKID;
          end
        end
        default: begin
          state_d = ST_EMPTY;
        end
      endcase
    end
  end

  // Output values derived from the next state so every output is a flop.
  always_comb begin
    occ_d       = 2'd0;
    out_valid_d = 1'b0;
    in_ready_d  = 1'b1;
    case (state_d)
      ST_EMPTY: begin
        occ_d       = 2'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
      ST_FULL: begin
        occ_d       = 2'd1;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b1;
      end
      ST_SKID: begin
        occ_d       = 2'd2;
        out_valid_d = 1'b1;
        in_ready_d  = 1'b0;
      end
      default: begin
        occ_d       = 2'd0;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
    out_we_d = out_valid_d && main_we_d && !we_killed(main_addr_d);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      main_we_q   <= 1'b0;
      main_addr_q <= {ADDR_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_we_q   <= 1'b0;
      skid_addr_q <= {ADDR_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_we_q    <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_we_q   <= main_we_d;
      main_addr_q <= main_addr_d;
      main_data_q <= main_data_d;
      skid_we_q   <= skid_we_d;
      skid_addr_q <= skid_addr_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_we_q    <= out_we_d;
      occ_q       <= occ_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_we    = out_we_q;
  assign out_addr  = main_addr_q;
  assign out_data  = main_data_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed vector table followed by randomized
// traffic checked against a queue-based reference model. Two instances share
// the stimulus: one with ZERO_KILL=1, one with ZERO_KILL=0.
module tb_pipe_skid_reg;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_we;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        flush;
  logic        out_ready;

  logic        in_ready, out_valid, out_we;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [1:0]  occ;

  logic        nk_in_ready, nk_out_valid, nk_out_we;
  logic [4:0]  nk_out_addr;
  logic [31:0] nk_out_data;
  logic [1:0]  nk_occ;

  int checks;
  int failures;

  pipe_skid_reg #(.DATA_W(32), .ADDR_W(5), .ZERO_KILL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_we(out_we),
    .out_addr(out_addr), .out_data(out_data), .occ(occ)
  );

  pipe_skid_reg #(.DATA_W(32), .ADDR_W(5), .ZERO_KILL(1'b0)) dut_nk (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(nk_in_ready),
    .in_we(in_we), .in_addr(in_addr), .in_data(in_data), .flush(flush),
    .out_valid(nk_out_valid), .out_ready(out_ready), .out_we(nk_out_we),
    .out_addr(nk_out_addr), .out_data(nk_out_data), .occ(nk_occ)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, iv, iwe;
    logic [4:0]  ia;
    logic [31:0] id;
    logic        ordy;
    logic        ev, ewe, ewe_nk;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        erdy;
    logic        efld;  // compare addr/data on this row
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  vec_t tbl[24];
  ent_t mq[$];

  function automatic vec_t mk(
    input logic r, input logic f, input logic iv, input logic iwe,
    input logic [4:0] ia, input logic [31:0] id, input logic ordy,
    input logic ev, input logic ewe, input logic ewe_nk,
    input logic [4:0] ea, input logic [31:0] ed,
    input logic [1:0] eocc, input logic erdy, input logic efld);
    vec_t v;
    v.rst = r; v.flush = f; v.iv = iv; v.iwe = iwe; v.ia = ia; v.id = id;
    v.ordy = ordy; v.ev = ev; v.ewe = ewe; v.ewe_nk = ewe_nk; v.ea = ea;
    v.ed = ed; v.eocc = eocc; v.erdy = erdy; v.efld = efld;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic iv, input logic iwe,
                       input logic [4:0] ia, input logic [31:0] id, input logic ordy);
    rst = r; flush = f; in_valid = iv; in_we = iwe;
    in_addr = ia; in_data = id; out_ready = ordy;
  endtask

  initial begin
    logic        acc, con, fld;
    logic [4:0]  da;
    logic [31:0] dd;
    logic        ev, ewe, ewe_nk;
    ent_t        e;
    logic        r, f, iv, ordy;

    clk = 1'b0;
    checks = 0;
    failures = 0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    //          rst   flush iv    iwe   ia     id        ordy  ev    ewe   ewe_nk ea     ed        occ   rdy   fld
    // reset
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b1);
    // streaming, out_ready held high
    tbl[1]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd3,  32'hA,    1'b1, 1'b1, 1'b1, 1'b1, 5'd3,  32'hA,    2'd1, 1'b1, 1'b1);
    tbl[2]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd4,  32'hB,    1'b1, 1'b1, 1'b1, 1'b1, 5'd4,  32'hB,    2'd1, 1'b1, 1'b1);
    tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b0);
    // backpressure into the skid register, then drain
    tbl[4]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd5,  32'hA,    1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  32'hA,    2'd1, 1'b1, 1'b1);
    tbl[5]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd6,  32'hB,    1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  32'hA,    2'd2, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd7,  32'hD,    1'b0, 1'b1, 1'b1, 1'b1, 5'd5,  32'hA,    2'd2, 1'b0, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b1, 1'b1, 1'b1, 5'd6,  32'hB,    2'd1, 1'b1, 1'b1);
    tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b0);
    // flush in SKID with an offered input
    tbl[9]  = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd8,  32'h1,    1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  32'h1,    2'd1, 1'b1, 1'b1);
    tbl[10] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd9,  32'h2,    1'b0, 1'b1, 1'b1, 1'b1, 5'd8,  32'h1,    2'd2, 1'b0, 1'b1);
    tbl[11] = mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 32'hC,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b1);
    tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b1);
    // flush in FULL with an input that would otherwise be accepted, plus consume
    tbl[13] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd11, 32'h3,    1'b0, 1'b1, 1'b1, 1'b1, 5'd11, 32'h3,    2'd1, 1'b1, 1'b1);
    tbl[14] = mk(1'b0, 1'b1, 1'b1, 1'b1, 5'd12, 32'h4,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b1);
    tbl[15] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b1);
    // write to register 0, then a we=0 entry
    tbl[16] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd0,  32'hFF,   1'b0, 1'b1, 1'b0, 1'b1, 5'd0,  32'hFF,   2'd1, 1'b1, 1'b1);
    tbl[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 5'd13, 32'h5,    1'b1, 1'b1, 1'b0, 1'b0, 5'd13, 32'h5,    2'd1, 1'b1, 1'b1);
    tbl[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b0);
    // reset while in SKID (with offered input), then normal latency
    tbl[19] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd14, 32'h6,    1'b0, 1'b1, 1'b1, 1'b1, 5'd14, 32'h6,    2'd1, 1'b1, 1'b1);
    tbl[20] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd15, 32'h7,    1'b0, 1'b1, 1'b1, 1'b1, 5'd14, 32'h6,    2'd2, 1'b0, 1'b1);
    tbl[21] = mk(1'b1, 1'b0, 1'b1, 1'b1, 5'd20, 32'h9,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b1);
    tbl[22] = mk(1'b0, 1'b0, 1'b1, 1'b1, 5'd16, 32'h8,    1'b0, 1'b1, 1'b1, 1'b1, 5'd16, 32'h8,    2'd1, 1'b1, 1'b1);
    tbl[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    1'b1, 1'b0, 1'b0, 1'b0, 5'd0,  32'h0,    2'd0, 1'b1, 1'b0);

    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      drive(tbl[i].rst, tbl[i].flush, tbl[i].iv, tbl[i].iwe, tbl[i].ia, tbl[i].id, tbl[i].ordy);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.valid", i), {31'd0, out_valid}, {31'd0, tbl[i].ev});
      chk($sformatf("tbl%0d.we", i), {31'd0, out_we}, {31'd0, tbl[i].ewe});
      chk($sformatf("tbl%0d.we_nk", i), {31'd0, nk_out_we}, {31'd0, tbl[i].ewe_nk});
      chk($sformatf("tbl%0d.occ", i), {30'd0, occ}, {30'd0, tbl[i].eocc});
      chk($sformatf("tbl%0d.ready", i), {31'd0, in_ready}, {31'd0, tbl[i].erdy});
      if (tbl[i].efld) begin
        chk($sformatf("tbl%0d.addr", i), {27'd0, out_addr}, {27'd0, tbl[i].ea});
        chk($sformatf("tbl%0d.data", i), out_data, tbl[i].ed);
      end
    end

    // Randomized traffic against a FIFO-queue reference model.
    da = 5'd0;
    dd = 32'd0;
    fld = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      r    = (c == 0) || ($urandom_range(0, 63) == 0);
      f    = ($urandom_range(0, 15) == 0);
      iv   = $urandom_range(0, 1) == 1;
      ordy = $urandom_range(0, 3) != 0;
      e.we   = $urandom_range(0, 3) != 0;
      e.addr = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      e.data = $urandom;
      drive(r, f, iv, e.we, e.addr, e.data, ordy);

      if (r || f) begin
        mq.delete();
        da = 5'd0;
        dd = 32'd0;
        fld = 1'b1;
      end else begin
        acc = iv && (mq.size() < 2);
        con = (mq.size() > 0) && ordy;
        if (con) void'(mq.pop_front());
        if (acc) mq.push_back(e);
        if (mq.size() > 0) begin
          da = mq[0].addr;
          dd = mq[0].data;
          fld = 1'b1;
        end else begin
          fld = 1'b0;
        end
      end
      ev     = mq.size() > 0;
      ewe    = ev && mq[0].we && (mq[0].addr != 5'd0);
      ewe_nk = ev && mq[0].we;

      @(posedge clk);
      #1;
      chk($sformatf("rnd%0d.valid", c), {31'd0, out_valid}, {31'd0, ev});
      chk($sformatf("rnd%0d.we", c), {31'd0, out_we}, {31'd0, ewe});
      chk($sformatf("rnd%0d.we_nk", c), {31'd0, nk_out_we}, {31'd0, ewe_nk});
      chk($sformatf("rnd%0d.occ", c), 32'(mq.size()), {30'd0, occ});
      chk($sformatf("rnd%0d.ready", c), {31'd0, in_ready}, {31'd0, mq.size() < 2});
      if (fld) begin
        chk($sformatf("rnd%0d.addr", c), {27'd0, out_addr}, {27'd0, da});
        chk($sformatf("rnd%0d.data", c), out_data, dd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
